// File: rtl/addsub_pipe.sv
// Carry-pipelined N_BIT adder/subtractor with valid/ready handshakes on both sides.
// Define ADDSUB_PIPE_SAT_EN to add the in_sat port and signed saturation of overflowing results.
module addsub_pipe #(
  parameter int N_BIT    = 32,
  parameter int N_STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_BIT-1:0] in_a,
  input  logic [N_BIT-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
`ifdef ADDSUB_PIPE_SAT_EN
  input  logic             in_sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_BIT-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int SEG  = (N_STAGES > 0) ? N_BIT / N_STAGES : N_BIT;
  localparam int LAST = N_STAGES - 1;

  if (N_STAGES < 1 || N_STAGES > N_BIT) begin : g_bad_stages
    $error("addsub_pipe: N_STAGES must lie in 1..N_BIT");
  end else if (N_BIT % N_STAGES != 0) begin : g_bad_split
    $error("addsub_pipe: N_BIT must be a multiple of N_STAGES");
  end

  logic                adv;
  logic [N_STAGES-1:0] vld_q, vld_d;
  logic [N_STAGES-1:0] cy_q, cy_d;
  logic                ovf_q, ovf_d;
  logic [N_BIT-1:0]    a_q   [N_STAGES];
  logic [N_BIT-1:0]    a_d   [N_STAGES];
  logic [N_BIT-1:0]    b_q   [N_STAGES];
  logic [N_BIT-1:0]    b_d   [N_STAGES];
  logic [N_BIT-1:0]    sum_q [N_STAGES];
  logic [N_BIT-1:0]    sum_d [N_STAGES];

  logic [N_BIT-1:0]    src_a   [N_STAGES];
  logic [N_BIT-1:0]    src_b   [N_STAGES];
  logic [N_BIT-1:0]    src_sum [N_STAGES];
  logic [N_STAGES-1:0] src_c;
  logic [N_STAGES-1:0] src_v;
  logic [SEG:0]        seg_res [N_STAGES];
  logic [N_BIT-1:0]    top_sum;
  logic                top_ovf;

`ifdef ADDSUB_PIPE_SAT_EN
  logic [N_STAGES-1:0] sat_q, sat_d;
  logic [N_STAGES-1:0] src_sat;
`endif

  assign adv       = !vld_q[LAST] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[LAST];
  assign out_sum   = sum_q[LAST];
  assign out_cout  = cy_q[LAST];
  assign out_ovf   = ovf_q;

  // Stage 0 sees the (already inverted for subtract) input beat; stage k sees stage k-1.
  always_comb begin
    src_a[0]   = in_a;
    src_b[0]   = in_sub ? ~in_b : in_b;
    src_c[0]   = in_sub ^ in_cin;
    src_sum[0] = '0;
    src_v[0]   = in_valid;
`ifdef ADDSUB_PIPE_SAT_EN
    src_sat[0] = in_sat;
`endif
    for (int k = 1; k < N_STAGES; k++) begin
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_c[k]   = cy_q[k-1];
      src_sum[k] = sum_q[k-1];
      src_v[k]   = vld_q[k-1];
`ifdef ADDSUB_PIPE_SAT_EN
      src_sat[k] = sat_q[k-1];
`endif
    end
  end

  always_comb begin
    for (int k = 0; k < N_STAGES; k++) begin
      seg_res[k] = {1'b0, src_a[k][k*SEG +: SEG]}
                 + {1'b0, src_b[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, src_c[k]};
    end
    top_sum = src_sum[LAST];
    top_sum[LAST*SEG +: SEG] = seg_res[LAST][SEG-1:0];
    top_ovf = (src_a[LAST][N_BIT-1] == src_b[LAST][N_BIT-1])
           && (top_sum[N_BIT-1] != src_a[LAST][N_BIT-1]);
`ifdef ADDSUB_PIPE_SAT_EN
    // Clamp toward the sign of A, which is the sign the true result carries on overflow.
    if (src_sat[LAST] && top_ovf) begin
      top_sum = src_a[LAST][N_BIT-1] ? {1'b1, {(N_BIT-1){1'b0}}}
                                     : {1'b0, {(N_BIT-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    vld_d = vld_q;
    cy_d  = cy_q;
    ovf_d = ovf_q;
`ifdef ADDSUB_PIPE_SAT_EN
    sat_d = sat_q;
`endif
    for (int k = 0; k < N_STAGES; k++) begin
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      sum_d[k] = sum_q[k];
    end
    if (adv) begin
      vld_d = src_v;
`ifdef ADDSUB_PIPE_SAT_EN
      sat_d = src_sat;
`endif
      for (int k = 0; k < N_STAGES; k++) begin
        a_d[k]   = src_a[k];
        b_d[k]   = src_b[k];
        cy_d[k]  = seg_res[k][SEG];
        sum_d[k] = src_sum[k];
        sum_d[k][k*SEG +: SEG] = seg_res[k][SEG-1:0];
      end
      sum_d[LAST] = top_sum;
      ovf_d       = top_ovf;
    end
  end

  // Only valid bits and the visible output registers are cleared; operand skew regs need no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      sum_q[LAST] <= '0;
      cy_q[LAST]  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      ovf_q <= ovf_d;
`ifdef ADDSUB_PIPE_SAT_EN
      sat_q <= sat_d;
`endif
      for (int k = 0; k < N_STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Randomized and directed self-checking bench for addsub_pipe (32 bits, 4 stages).
// With ADDSUB_PIPE_SAT_EN defined the in_sat port and saturation vectors are exercised too.
module tb_addsub_pipe;

  localparam int N_BIT    = 32;
  localparam int N_STAGES = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N_BIT-1:0] in_a;
  logic [N_BIT-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
`ifdef ADDSUB_PIPE_SAT_EN
  logic             in_sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [N_BIT-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc_cyc;
    int          acc_stalls;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   stall_cnt = 0;
  int   run_len = 0;
  int   max_run = 0;
  logic rand_ready = 1'b0;

  addsub_pipe #(.N_BIT(N_BIT), .N_STAGES(N_STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
`ifdef ADDSUB_PIPE_SAT_EN
    .in_sat    (in_sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Reference: exact signed/unsigned integer arithmetic on the operands.
  function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                     input logic cin, input logic sub, input logic sat);
    exp_t   e;
    longint sa, sb, ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    if (sub) begin
      r      = sa - sb - longint'(cin);
      e.cout = (ua >= ub + longint'(cin));
    end else begin
      r      = sa + sb + longint'(cin);
      e.cout = ((ua + ub + longint'(cin)) >> 32) != 0;
    end
    e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e.sum = r[31:0];
    if (sat && e.ovf) e.sum = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    e.acc_cyc    = 0;
    e.acc_stalls = 0;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: records accepted beats and checks every popped or stalled result.
  initial begin
    exp_t e;
    logic sat_bit;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        run_len = 0;
      end else begin
        if (out_valid) run_len++;
        else run_len = 0;
        if (run_len > max_run) max_run = run_len;
        if (out_valid && !out_ready) begin
          stall_cnt++;
          if (exp_q.size() > 0) checkOutput("stall_sum", out_sum, exp_q[0].sum);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("spurious_out", 1, 0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("sum", out_sum, e.sum);
            checkOutput("cout", out_cout, e.cout);
            checkOutput("ovf", out_ovf, e.ovf);
            if (e.acc_stalls == stall_cnt)
              checkOutput("latency", 64'(cyc - e.acc_cyc), N_STAGES);
          end
        end
        if (in_valid && in_ready) begin
`ifdef ADDSUB_PIPE_SAT_EN
          sat_bit = in_sat;
`else
          sat_bit = 1'b0;
`endif
          e = ref_model(in_a, in_b, in_cin, in_sub, sat_bit);
          e.acc_cyc    = cyc;
          e.acc_stalls = stall_cnt;
          exp_q.push_back(e);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic cin, input logic sub, input logic sat);
    int n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
`ifdef ADDSUB_PIPE_SAT_EN
    in_sat   = sat;
`else
    if (sat) n = 0;
`endif
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic runVector(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub, input logic sat,
                           input logic [31:0] x_sum, input logic x_cout, input logic x_ovf);
    int n = 0;
    applyStimulus(a, b, cin, sub, sat);
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, out_valid, 1);
    checkOutput({tag, "_sum"}, out_sum, x_sum);
    checkOutput({tag, "_cout"}, out_cout, x_cout);
    checkOutput({tag, "_ovf"}, out_ovf, x_ovf);
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    int n = 0;
    @(negedge clk);
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
`ifdef ADDSUB_PIPE_SAT_EN
    in_sat    = 1'b0;
`endif
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_sum", out_sum, 0);
    checkOutput("reset_cout", out_cout, 0);
    checkOutput("reset_ovf", out_ovf, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    runVector("carry", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    runVector("ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    runVector("sub1", 32'd5, 32'd7, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    runVector("sub2", 32'd7, 32'd5, 1'b1, 1'b1, 1'b0, 32'h1, 1'b1, 1'b0);
`ifdef ADDSUB_PIPE_SAT_EN
    runVector("sat_pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    runVector("sat_neg", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
`endif

    $display("[TB] back-to-back streaming");
    max_run = 0;
    for (int i = 0; i < 16; i++) applyStimulus(32'(i), 32'(i) << 16, 1'b0, 1'b0, 1'b0);
    waitDrain();
    checkOutput("stream_run", max_run, 16);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(rand_word(), rand_word(), 1'(i), 1'(i >> 1), 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", in_ready, 0);
      checkOutput("stall_valid", out_valid, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_in_ready", in_ready, 1);
    waitDrain();

    $display("[TB] random traffic");
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(rand_word(), rand_word(), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    waitDrain();

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 3; i++) applyStimulus(rand_word(), rand_word(), 1'b0, 1'b0, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_a     = 32'h1234_5678;
    in_b     = 32'h1111_1111;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("midrst_valid", out_valid, 0);
    checkOutput("midrst_sum", out_sum, 0);
    checkOutput("midrst_cout", out_cout, 0);
    checkOutput("midrst_ovf", out_ovf, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("midrst_no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;
    runVector("recover", 32'd3, 32'd4, 1'b1, 1'b0, 1'b0, 32'd8, 1'b0, 1'b0);
    waitDrain();
    checkOutput("leftover", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
